// File: rtl/game_state_if.sv
// Button/pulse inputs and registered status outputs of game_state_ctrl.
interface game_state_if #(
  parameter int LIVES_W = 2,
  parameter int LEVEL_W = 3
);
  logic               start;
  logic               restart;
  logic               pause;
  logic               die;
  logic               level_done;
  logic [2:0]         state;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;
  logic               state_changed;

  modport master (
    output start, restart, pause, die, level_done,
    input  state, lives, level, state_changed
  );

  modport slave (
    input  start, restart, pause, die, level_done,
    output state, lives, level, state_changed
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Game flow controller: lives, levels, pause, timed LEVEL_CLEAR/OVER/WIN holds.
// GAME_AUTO_RETURN_EN: OVER/WIN return to INIT after OVER_HOLD cycles.
//   state       | meaning
//   INIT        | waiting for start, lives/level reloaded
//   RUNNING     | gameplay
//   OVER        | out of lives
//   PAUSED      | gameplay frozen
//   LEVEL_CLEAR | timed hold before next level
//   WIN         | last level cleared
module game_state_ctrl #(
  parameter int MAX_LIVES  = 3,
  parameter int LIVES_W    = 2,
  parameter int MAX_LEVEL  = 4,
  parameter int LEVEL_W    = 3,
  parameter int CLEAR_HOLD = 50000000,
  parameter int OVER_HOLD  = 100000000,
  parameter int HOLD_W     = 27
) (
  input  logic         clk,
  input  logic         rst,
  game_state_if.slave  gs
);
  localparam logic [2:0] S_INIT        = 3'd0;
  localparam logic [2:0] S_RUNNING     = 3'd1;
  localparam logic [2:0] S_OVER        = 3'd2;
  localparam logic [2:0] S_PAUSED      = 3'd3;
  localparam logic [2:0] S_LEVEL_CLEAR = 3'd4;
  localparam logic [2:0] S_WIN         = 3'd5;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(MAX_LEVEL - 1);
  localparam logic [HOLD_W-1:0]  CLEAR_TC   = HOLD_W'(CLEAR_HOLD - 1);

  if (MAX_LIVES < 1 || MAX_LEVEL < 1 || CLEAR_HOLD < 1 || OVER_HOLD < 1) begin : g_bad_param
    $error("game_state_ctrl: MAX_LIVES, MAX_LEVEL, CLEAR_HOLD and OVER_HOLD must be >= 1");
  end

  logic               start_q, restart_q, pause_q;
  logic               start_p, restart_p, pause_p;
  logic [2:0]         state_r, next_state;
  logic [LIVES_W-1:0] lives_r, next_lives;
  logic [LEVEL_W-1:0] level_r, next_level;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               state_changed_r;
  logic               hold_active;
  logic               over_expired;

  assign start_p   = gs.start   & ~start_q;
  assign restart_p = gs.restart & ~restart_q;
  assign pause_p   = gs.pause   & ~pause_q;

`ifdef GAME_AUTO_RETURN_EN
  localparam logic [HOLD_W-1:0] OVER_TC = HOLD_W'(OVER_HOLD - 1);
  assign hold_active  = (state_r == S_LEVEL_CLEAR) || (state_r == S_OVER) || (state_r == S_WIN);
  assign over_expired = (hold_cnt == OVER_TC);
`else
  assign hold_active  = (state_r == S_LEVEL_CLEAR);
  assign over_expired = 1'b0;
`endif

  always_comb begin
    next_state = state_r;
    next_lives = lives_r;
    next_level = level_r;
    case (state_r)
      S_INIT: begin
        if (start_p && !gs.restart) next_state = S_RUNNING;
      end
      S_RUNNING: begin
        if (restart_p) begin
          next_state = S_INIT;
        end else if (gs.die) begin
          if (lives_r > LIVES_W'(1)) begin
            next_lives = lives_r - 1'b1;
          end else begin
            next_lives = '0;
            next_state = S_OVER;
          end
        end else if (gs.level_done) begin
          next_state = (level_r >= LEVEL_LAST) ? S_WIN : S_LEVEL_CLEAR;
        end else if (pause_p) begin
          next_state = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (restart_p)                next_state = S_INIT;
        else if (pause_p || start_p)  next_state = S_RUNNING;
      end
      S_LEVEL_CLEAR: begin
        if (restart_p) begin
          next_state = S_INIT;
        end else if (hold_cnt == CLEAR_TC) begin
          next_state = S_RUNNING;
          if (level_r < LEVEL_LAST) next_level = level_r + 1'b1;
        end
      end
      S_OVER, S_WIN: begin
        if (restart_p || over_expired) next_state = S_INIT;
      end
      default: next_state = S_INIT;
    endcase
    // Every path into (or staying in) INIT reloads, including undefined-state recovery.
    if (next_state == S_INIT) begin
      next_lives = LIVES_INIT;
      next_level = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q         <= 1'b1;
      restart_q       <= 1'b1;
      pause_q         <= 1'b1;
      state_r         <= S_INIT;
      lives_r         <= LIVES_INIT;
      level_r         <= '0;
      state_changed_r <= 1'b0;
      hold_cnt        <= '0;
    end else begin
      start_q         <= gs.start;
      restart_q       <= gs.restart;
      pause_q         <= gs.pause;
      state_r         <= next_state;
      lives_r         <= next_lives;
      level_r         <= next_level;
      state_changed_r <= (next_state != state_r);
      if (next_state != state_r)  hold_cnt <= '0;
      else if (hold_active)       hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign gs.state         = state_r;
  assign gs.lives         = lives_r;
  assign gs.level         = level_r;
  assign gs.state_changed = state_changed_r;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: directed test-plan scenarios plus random stimulus.
module tb_game_state_ctrl;
  localparam int MAX_LIVES  = 3;
  localparam int LIVES_W    = 2;
  localparam int MAX_LEVEL  = 2;
  localparam int LEVEL_W    = 3;
  localparam int CLEAR_HOLD = 4;
  localparam int OVER_HOLD  = 8;
  localparam int HOLD_W     = 4;

  localparam int ST_INIT = 0, ST_RUN = 1, ST_OVER = 2, ST_PAUSE = 3, ST_CLEAR = 4, ST_WIN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  game_state_if #(.LIVES_W(LIVES_W), .LEVEL_W(LEVEL_W)) gs();

  game_state_ctrl #(
    .MAX_LIVES(MAX_LIVES), .LIVES_W(LIVES_W), .MAX_LEVEL(MAX_LEVEL), .LEVEL_W(LEVEL_W),
    .CLEAR_HOLD(CLEAR_HOLD), .OVER_HOLD(OVER_HOLD), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gs(gs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int state;
    int lives;
    int level;
    int changed;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: game rules in plain integers; hold time measured as cycles since entry.
  int m_state = ST_INIT, m_lives = MAX_LIVES, m_level = 0, m_changed = 0;
  int m_cyc = 0, m_entry = 0;
  bit m_sq = 1'b1, m_rq = 1'b1, m_pq = 1'b1;

  function automatic void model(input bit r, input bit s, input bit rs, input bit p,
                                input bit d, input bit ld);
    bit sp, rp, pp;
    int nxt, elapsed;
    m_cyc++;
    if (r) begin
      m_state = ST_INIT; m_lives = MAX_LIVES; m_level = 0; m_changed = 0;
      m_entry = m_cyc; m_sq = 1'b1; m_rq = 1'b1; m_pq = 1'b1;
      return;
    end
    sp = s && !m_sq;
    rp = rs && !m_rq;
    pp = p && !m_pq;
    m_sq = s; m_rq = rs; m_pq = p;
    elapsed = m_cyc - m_entry;
    nxt = m_state;
    if (rp) begin
      nxt = ST_INIT;
    end else begin
      case (m_state)
        ST_INIT:  if (sp && !rs) nxt = ST_RUN;
        ST_RUN: begin
          if (d) begin
            if (m_lives > 1) m_lives = m_lives - 1;
            else begin m_lives = 0; nxt = ST_OVER; end
          end else if (ld) begin
            nxt = (m_level == MAX_LEVEL - 1) ? ST_WIN : ST_CLEAR;
          end else if (pp) begin
            nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: if (pp || sp) nxt = ST_RUN;
        ST_CLEAR: if (elapsed == CLEAR_HOLD) begin nxt = ST_RUN; m_level = m_level + 1; end
`ifdef GAME_AUTO_RETURN_EN
        ST_OVER, ST_WIN: if (elapsed == OVER_HOLD) nxt = ST_INIT;
`endif
        default: ;
      endcase
    end
    if (nxt == ST_INIT) begin m_lives = MAX_LIVES; m_level = 0; end
    m_changed = (nxt != m_state) ? 1 : 0;
    if (nxt != m_state) m_entry = m_cyc;
    m_state = nxt;
  endfunction

  task automatic step(input bit r, input bit s, input bit rs, input bit p,
                      input bit d, input bit ld);
    exp_t e;
    @(negedge clk);
    rst = r; gs.start = s; gs.restart = rs; gs.pause = p; gs.die = d; gs.level_done = ld;
    model(r, s, rs, p, d, ld);
    e.state = m_state; e.lives = m_lives; e.level = m_level; e.changed = m_changed; e.cyc = m_cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int want, input int cyc);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  // Monitor: outputs are registered, so one expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",         int'(gs.state),         e.state,   e.cyc);
        chk("lives",         int'(gs.lives),         e.lives,   e.cyc);
        chk("level",         int'(gs.level),         e.level,   e.cyc);
        chk("state_changed", int'(gs.state_changed), e.changed, e.cyc);
      end
    end
  end

  initial begin
    bit s_lvl, r_lvl, p_lvl;
    gs.start = 1'b0; gs.restart = 1'b0; gs.pause = 1'b0; gs.die = 1'b0; gs.level_done = 1'b0;

    // Start held through reset must not fire until it is released and pressed again.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Three deaths to OVER, then restart.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
    end
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Pause, die ignored while paused, resume.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Level clear hold, then the final level gives WIN.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Die and level_done together on the last life.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Restart edge beats die in the same cycle.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Sit in OVER for 20 cycles (auto-return or sticky), then restart.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
    end
    idle(20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Random play: button levels toggle occasionally, pulses fire sparsely.
    s_lvl = 1'b0; r_lvl = 1'b0; p_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)  s_lvl = ~s_lvl;
      if (r_lvl) begin
        if ($urandom_range(0, 2) == 0) r_lvl = 1'b0;
      end else if ($urandom_range(0, 60) == 0) begin
        r_lvl = 1'b1;
      end
      if ($urandom_range(0, 9) == 0)  p_lvl = ~p_lvl;
      step(($urandom_range(0, 399) == 0), s_lvl, r_lvl, p_lvl,
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
